// File: rtl/modmul_arbiter_pkg.sv
// Shared types and constants for the modular-multiplier arbiter.
package modmul_arbiter_pkg;
    localparam int MODMUL_DATA_WIDTH = 2048;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    typedef struct packed {
        logic [MODMUL_DATA_WIDTH-1:0] a;
        logic [MODMUL_DATA_WIDTH-1:0] b;
        logic [MODMUL_DATA_WIDTH-1:0] m;
    } modmul_req_t;
endpackage

// File: rtl/modmul_arbiter_if.sv
// Requester-facing request/response channels of the shared modmul arbiter.
interface modmul_arbiter_if
    import modmul_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = MODMUL_DATA_WIDTH
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_m;
    logic [NUM_REQ-1:0]                 rsp_valid;
    logic [NUM_REQ-1:0]                 rsp_ready;
    logic [DATA_WIDTH-1:0]              rsp_data;

    modport master (
        output req_valid, req_a, req_b, req_m, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_m, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/modmul_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after rr_ptr, cyclic.
module modmul_arbiter_rr_pick
    import modmul_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    grant,
    output logic               any_valid
);
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    assign any_valid = |valid;
endmodule

// File: rtl/modmul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle a*b mod m unit between NUM_REQ requesters.
module modmul_arbiter
    import modmul_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = MODMUL_DATA_WIDTH,
    parameter int TIMEOUT    = 65535,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    modmul_arbiter_if.slave       bus,
    output logic                  mm_start,
    output logic [DATA_WIDTH-1:0] mm_a,
    output logic [DATA_WIDTH-1:0] mm_b,
    output logic [DATA_WIDTH-1:0] mm_m,
    input  logic                  mm_done,
    input  logic [DATA_WIDTH-1:0] mm_result,
    output logic [ID_W-1:0]       owner,
    output logic                  busy,
    output logic                  err_timeout
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t      state, state_nxt;
    logic [ID_W-1:0] rr_ptr, grant;
    logic            any_valid;
    logic [WD_W-1:0] watchdog;

    modmul_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .valid     (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .any_valid (any_valid)
    );

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        mm_start      = 1'b0;
        case (state)
            IDLE: if (any_valid) begin
                bus.req_ready[grant] = 1'b1;
                state_nxt            = ISSUE;
            end
            ISSUE: begin
                mm_start  = 1'b1;
                state_nxt = WAIT;
            end
            // done takes priority over a watchdog expiring in the same cycle
            WAIT: if (mm_done) state_nxt = RESP;
                  else if (watchdog == WD_LAST) state_nxt = IDLE;
            RESP: begin
                bus.rsp_valid[owner] = 1'b1;
                if (bus.rsp_ready[owner]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            watchdog     <= '0;
            mm_a         <= '0;
            mm_b         <= '0;
            mm_m         <= '0;
            bus.rsp_data <= '0;
            err_timeout  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (any_valid) begin
                    mm_a   <= bus.req_a[grant];
                    mm_b   <= bus.req_b[grant];
                    mm_m   <= bus.req_m[grant];
                    owner  <= grant;
                    rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                end
                ISSUE: watchdog <= '0;
                WAIT: begin
                    watchdog <= watchdog + 1'b1;
                    if (mm_done) bus.rsp_data <= mm_result;
                    else if (watchdog == WD_LAST) err_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_modmul_arbiter.sv
// Scoreboard bench for modmul_arbiter with a fixed 4-cycle stub multiplier, 16-bit data.
module tb_modmul_arbiter;
    localparam int N  = 3;
    localparam int DW = 16;
    localparam int TO = 8;
    localparam int NV = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    modmul_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    logic          mm_start, mm_done;
    logic [DW-1:0] mm_a, mm_b, mm_m, mm_result;
    logic [1:0]    owner;
    logic          busy, err_timeout;

    modmul_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .mm_start    (mm_start),
        .mm_a        (mm_a),
        .mm_b        (mm_b),
        .mm_m        (mm_m),
        .mm_done     (mm_done),
        .mm_result   (mm_result),
        .owner       (owner),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    // stub multiplier: done pulses 4 cycles after the start cycle unless hung
    logic [2:0] stub_cnt;
    bit hang = 1'b0;
    bit spur = 1'b0;
    always @(posedge clk) begin
        if (!rst_n) begin
            stub_cnt  <= '0;
            mm_result <= '0;
        end else if (mm_start) begin
            stub_cnt  <= 3'd4;
            mm_result <= DW'((32'(mm_a) * 32'(mm_b)) % 32'(mm_m));
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1'b1;
        end
    end
    assign mm_done = (stub_cnt == 3'd1 && !hang) || spur;

    typedef struct {int id; logic [DW-1:0] data;} exp_t;
    typedef struct {int id; logic [DW-1:0] a, b, m, e; bit chain;} vec_t;

    exp_t          exp_q[$];
    int            grant_q[$];
    vec_t          tbl[NV];
    int            nxt_idx[N];
    logic [DW-1:0] cur_exp[N];
    bit            cur_chain[N];
    bit [N-1:0]    acc;
    bit            no_rsp = 1'b0;
    int            total = 0;
    int            bad = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endfunction

    // response monitor: pops the scoreboard on every response handshake
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n && bus.rsp_valid != 0) begin
            chk("rsp_onehot", 32'($onehot(bus.rsp_valid)), 32'd1);
            if ((bus.rsp_valid & bus.rsp_ready) != 0) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_id", 32'(bus.rsp_valid), 32'd1 << e.id);
                    chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                end
            end
        end
    end

    task automatic load(int i);
        bit found = 1'b0;
        for (int k = nxt_idx[i]; k < NV; k++) begin
            if (!found && tbl[k].id == i) begin
                bus.req_a[i]     = tbl[k].a;
                bus.req_b[i]     = tbl[k].b;
                bus.req_m[i]     = tbl[k].m;
                bus.req_valid[i] = 1'b1;
                cur_exp[i]       = tbl[k].e;
                cur_chain[i]     = tbl[k].chain;
                nxt_idx[i]       = k + 1;
                found            = 1'b1;
            end
        end
        if (!found) bus.req_valid[i] = 1'b0;
    endtask

    // one clock: record accepted requests, then retire/reload them after the edge
    task automatic nxt();
        #1;
        chk("req_ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
        chk("req_ready_not_idle", 32'(bus.req_ready != 0 && busy), 32'd0);
        for (int i = 0; i < N; i++) begin
            acc[i] = bus.req_valid[i] && bus.req_ready[i];
            if (acc[i]) begin
                grant_q.push_back(i);
                if (!no_rsp) exp_q.push_back(exp_t'{i, cur_exp[i]});
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (cur_chain[i]) load(i);
                else bus.req_valid[i] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_idle(int budget, string nm);
        int n = 0;
        while ((bus.req_valid != 0 || busy || exp_q.size() != 0) && n < budget) begin
            nxt();
            n++;
        end
        chk(nm, 32'(bus.req_valid == 0 && !busy && exp_q.size() == 0), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rr_exp[4] = '{0, 1, 2, 0};
        int gsz;
        int n;

        tbl[0]  = '{0, 16'd2,  16'd3,  16'd11, 16'd6, 1'b1};
        tbl[1]  = '{1, 16'd4,  16'd4,  16'd13, 16'd3, 1'b0};
        tbl[2]  = '{2, 16'd6,  16'd6,  16'd17, 16'd2, 1'b0};
        tbl[3]  = '{0, 16'd3,  16'd5,  16'd7,  16'd1, 1'b0};
        tbl[4]  = '{0, 16'd3,  16'd5,  16'd7,  16'd1, 1'b0};
        tbl[5]  = '{1, 16'd5,  16'd5,  16'd9,  16'd7, 1'b0};
        tbl[6]  = '{0, 16'd7,  16'd8,  16'd10, 16'd6, 1'b0};
        tbl[7]  = '{2, 16'd9,  16'd9,  16'd20, 16'd1, 1'b0};
        tbl[8]  = '{2, 16'd10, 16'd3,  16'd7,  16'd2, 1'b0};
        tbl[9]  = '{0, 16'd12, 16'd12, 16'd23, 16'd6, 1'b0};
        tbl[10] = '{0, 16'd2,  16'd2,  16'd5,  16'd4, 1'b0};
        tbl[11] = '{1, 16'd3,  16'd3,  16'd5,  16'd4, 1'b0};
        tbl[12] = '{2, 16'd4,  16'd4,  16'd7,  16'd2, 1'b0};
        for (int i = 0; i < N; i++) nxt_idx[i] = 0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_m     = '0;
        bus.rsp_ready = '1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_start", 32'(mm_start), 32'd0);
        chk("rst_mm_a", 32'(mm_a), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // round-robin with all requesters holding valid
        grant_q.delete();
        load(0); load(1); load(2);
        run_idle(60, "rr_done");
        chk("rr_count", 32'(grant_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < grant_q.size(); k++)
            chk("rr_order", 32'(grant_q[k]), 32'(rr_exp[k]));

        // single request, cycle-exact
        load(0);
        #1 chk("single_ready", 32'(bus.req_ready), 32'd1);
        nxt();
        chk("single_start", 32'(mm_start), 32'd1);
        chk("single_mm_a", 32'(mm_a), 32'd3);
        chk("single_mm_b", 32'(mm_b), 32'd5);
        chk("single_mm_m", 32'(mm_m), 32'd7);
        chk("single_busy", 32'(busy), 32'd1);
        repeat (4) nxt();
        chk("single_early", 32'(bus.rsp_valid), 32'd0);
        nxt();
        chk("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("single_rsp_data", 32'(bus.rsp_data), 32'd1);
        nxt();
        chk("single_rsp_clear", 32'(bus.rsp_valid), 32'd0);
        chk("single_idle", 32'(busy), 32'd0);

        // spurious done while idle
        spur = 1'b1;
        nxt();
        spur = 1'b0;
        chk("spur_busy", 32'(busy), 32'd0);
        chk("spur_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("spur_data", 32'(bus.rsp_data), 32'd1);
        nxt();
        chk("spur_busy2", 32'(busy), 32'd0);

        // backpressure on requester 1 with requester 0 waiting
        bus.rsp_ready = 3'b101;
        load(1);
        nxt();
        load(0);
        n = 0;
        while (bus.rsp_valid[1] !== 1'b1 && n < 20) begin nxt(); n++; end
        chk("bp_reach", 32'(bus.rsp_valid[1]), 32'd1);
        gsz = grant_q.size();
        repeat (10) begin
            chk("bp_valid", 32'(bus.rsp_valid), 32'd2);
            chk("bp_data", 32'(bus.rsp_data), 32'd7);
            chk("bp_busy", 32'(busy), 32'd1);
            nxt();
        end
        chk("bp_nogrant", 32'(grant_q.size()), 32'(gsz));
        bus.rsp_ready = '1;
        run_idle(40, "bp_done");

        // watchdog timeout with a hung multiplier
        hang = 1'b1;
        no_rsp = 1'b1;
        load(2);
        nxt();
        no_rsp = 1'b0;
        chk("to_start", 32'(mm_start), 32'd1);
        repeat (7) nxt();
        chk("to_err_early", 32'(err_timeout), 32'd0);
        chk("to_busy", 32'(busy), 32'd1);
        repeat (2) nxt();
        chk("to_err", 32'(err_timeout), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_no_rsp", 32'(bus.rsp_valid), 32'd0);
        hang = 1'b0;
        load(2);
        run_idle(40, "to_recover");
        chk("to_sticky", 32'(err_timeout), 32'd1);

        // reset in the middle of WAIT
        no_rsp = 1'b1;
        load(0);
        nxt();
        no_rsp = 1'b0;
        repeat (2) nxt();
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_busy_clr", 32'(busy), 32'd0);
        chk("mid_err_clr", 32'(err_timeout), 32'd0);
        chk("mid_start", 32'(mm_start), 32'd0);
        chk("mid_mm_a", 32'(mm_a), 32'd0);
        chk("mid_mm_b", 32'(mm_b), 32'd0);
        chk("mid_mm_m", 32'(mm_m), 32'd0);
        chk("mid_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_owner", 32'(owner), 32'd0);
        grant_q.delete();
        load(0); load(1); load(2);
        run_idle(80, "post_rst_done");
        chk("post_rst_count", 32'(grant_q.size()), 32'd3);
        if (grant_q.size() > 0) chk("post_rst_first", 32'(grant_q[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
